// File: rtl/adder_pkg.sv
// Shared encodings and helpers for the bit-serial add/subtract datapaths.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } st_e;

  // Bit-counter width; at least one bit for the degenerate small widths.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor_full_sub.sv
// 1-bit full-subtractor cell: diff = a ^ b ^ bin, borrow when a < b + bin.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (bin & ~(a ^ b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through one full_sub cell.
module serial_subtractor
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  st_e              state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] d_sr;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;

  logic             d_bit;
  logic             brw_nxt;
  logic [WIDTH-1:0] d_nxt;

  full_sub u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw),
    .diff (d_bit),
    .bout (brw_nxt)
  );

  // New bit enters at the MSB; after WIDTH steps the first bit has reached bit 0.
  assign d_nxt = {d_bit, d_sr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      diff_r <= '0;
      bout_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        // DONE accepts a new request exactly like IDLE for back-to-back operation.
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            brw    <= bus.bin;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= ST_SHIFT;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= d_nxt[WIDTH-1:1];
          brw  <= brw_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff_r <= d_nxt;
            bout_r <= brw_nxt;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= ST_DONE;
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;

endmodule
